// File: rtl/csr_file_m.sv
// Machine-mode CSR unit: two combinational read ports, one CSR-instruction write port,
// mcycle/minstret counters, trap-entry/mret sequencing and interrupt-pending generation.
module csr_file_m #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MISA_VALUE  = 32'h40000100,
  parameter logic [31:0] MTVEC_RESET = 32'h00000000,
  parameter int          CNT_WIDTH   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rd1_addr,
  output logic [31:0] rd1_data,
  input  logic [11:0] rd2_addr,
  output logic [31:0] rd2_data,
  input  logic        wr_en,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  wr_op,
  input  logic [31:0] wr_data,
  output logic        wr_illegal,
  input  logic        instr_retire,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_epc,
  input  logic [31:0] trap_tval,
  input  logic        mret,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic        irq_ext,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out,
  output logic        irq_pending
);

  logic                 st_mie, st_mpie;
  logic [31:0]          mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [CNT_WIDTH-1:0] mcycle_q, minstret_q, mcycle_d, minstret_d;
  logic [63:0]          mcycle_ext, minstret_ext, cyc_tmp, ret_tmp;
  logic [31:0]          mip, wr_old, wr_val;
  logic                 wr_hit, wr_do;
  logic [32:0]          rd1_lk, rd2_lk, wr_lk;

  assign mip = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};

  always_comb begin
    mcycle_ext                  = '0;
    minstret_ext                = '0;
    mcycle_ext[CNT_WIDTH-1:0]   = mcycle_q;
    minstret_ext[CNT_WIDTH-1:0] = minstret_q;
  end

  // Returns {implemented, read value} for a CSR address.
  function automatic logic [32:0] csr_lookup(input logic [11:0] a);
    case (a)
      12'h300: return {1'b1, 19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
      12'h301: return {1'b1, MISA_VALUE};
      12'h304: return {1'b1, mie_q};
      12'h305: return {1'b1, mtvec_q};
      12'h340: return {1'b1, mscratch_q};
      12'h341: return {1'b1, mepc_q};
      12'h342: return {1'b1, mcause_q};
      12'h343: return {1'b1, mtval_q};
      12'h344: return {1'b1, mip};
      12'hF14: return {1'b1, HART_ID};
      12'hB00, 12'hC00: return {1'b1, mcycle_ext[31:0]};
      12'hB80, 12'hC80: return {1'b1, mcycle_ext[63:32]};
      12'hB02, 12'hC02: return {1'b1, minstret_ext[31:0]};
      12'hB82, 12'hC82: return {1'b1, minstret_ext[63:32]};
      default: return 33'b0;
    endcase
  endfunction

  always_comb begin
    rd1_lk = csr_lookup(rd1_addr);
    rd2_lk = csr_lookup(rd2_addr);
    wr_lk  = csr_lookup(wr_addr);
  end

  assign rd1_data = rd1_lk[31:0];
  assign rd2_data = rd2_lk[31:0];
  assign wr_hit   = wr_lk[32];
  assign wr_old   = wr_lk[31:0];

  // Illegality depends only on the address; trap/mret merely drop a legal write.
  assign wr_illegal = wr_en && (wr_op != 2'b00) && ((wr_addr[11:10] == 2'b11) || !wr_hit);
  assign wr_do      = wr_en && (wr_op != 2'b00) && !wr_illegal && !trap_valid && !mret;

  always_comb begin
    case (wr_op)
      2'b10:   wr_val = wr_old | wr_data;
      2'b11:   wr_val = wr_old & ~wr_data;
      default: wr_val = wr_data;
    endcase
  end

  always_comb begin
    cyc_tmp = mcycle_ext + 64'd1;
    ret_tmp = minstret_ext + {63'b0, instr_retire};
    if (wr_do && wr_addr == 12'hB00) cyc_tmp = {mcycle_ext[63:32], wr_val};
    if (wr_do && wr_addr == 12'hB80) cyc_tmp = {wr_val, mcycle_ext[31:0]};
    if (wr_do && wr_addr == 12'hB02) ret_tmp = {minstret_ext[63:32], wr_val};
    if (wr_do && wr_addr == 12'hB82) ret_tmp = {wr_val, minstret_ext[31:0]};
    mcycle_d   = cyc_tmp[CNT_WIDTH-1:0];
    minstret_d = ret_tmp[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      if (trap_valid) begin
        mepc_q   <= trap_epc & ~32'd3;
        mcause_q <= trap_cause;
        mtval_q  <= trap_tval;
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
      end else if (mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (wr_do) begin
        case (wr_addr)
          12'h300: begin
            st_mie  <= wr_val[3];
            st_mpie <= wr_val[7];
          end
          12'h304: mie_q      <= wr_val & 32'h00000888;
          12'h305: mtvec_q    <= wr_val & ~32'd2;
          12'h340: mscratch_q <= wr_val;
          12'h341: mepc_q     <= wr_val & ~32'd3;
          12'h342: mcause_q   <= wr_val;
          12'h343: mtval_q    <= wr_val;
          default: ;
        endcase
      end
    end
  end

  assign mtvec_out   = mtvec_q;
  assign mepc_out    = mepc_q;
  assign irq_pending = st_mie && |(mie_q & mip);

endmodule

// File: tb/tb_csr_file_m.sv
// Bench for csr_file_m: an architectural CSR model checked every cycle, plus directed
// vectors with hand-computed expectations.
module tb_csr_file_m;
  localparam logic [31:0] HART_ID     = 32'd5;
  localparam logic [31:0] MISA_VALUE  = 32'h40000100;
  localparam logic [31:0] MTVEC_RESET = 32'h00002000;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] rd1_addr, rd2_addr, wr_addr;
  logic [31:0] rd1_data, rd2_data, wr_data;
  logic        wr_en, wr_illegal, instr_retire, trap_valid, mret;
  logic [1:0]  wr_op;
  logic [31:0] trap_cause, trap_epc, trap_tval, mtvec_out, mepc_out;
  logic        irq_sw, irq_timer, irq_ext, irq_pending;

  int n_tests = 0;
  int n_fail  = 0;

  csr_file_m #(.HART_ID(HART_ID), .MISA_VALUE(MISA_VALUE), .MTVEC_RESET(MTVEC_RESET),
               .CNT_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .rd1_addr(rd1_addr), .rd1_data(rd1_data), .rd2_addr(rd2_addr), .rd2_data(rd2_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_op(wr_op), .wr_data(wr_data),
    .wr_illegal(wr_illegal), .instr_retire(instr_retire),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_epc(trap_epc),
    .trap_tval(trap_tval), .mret(mret),
    .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext),
    .mtvec_out(mtvec_out), .mepc_out(mepc_out), .irq_pending(irq_pending)
  );

  // clock / reset
  always #5 clk = ~clk;

  // architectural model
  bit          m_valid = 1'b0;
  bit          m_mie, m_mpie;
  logic [31:0] m_ie, m_tvec, m_scratch, m_epc, m_cause, m_tval;
  logic [63:0] m_cycle, m_instret;

  function automatic bit m_known(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
      12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82:
        return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    logic [31:0] v;
    v = 32'h0;
    case (a)
      12'h300: v = 32'h1800 + (m_mie ? 32'h8 : 32'h0) + (m_mpie ? 32'h80 : 32'h0);
      12'h301: v = MISA_VALUE;
      12'h304: v = m_ie;
      12'h305: v = m_tvec;
      12'h340: v = m_scratch;
      12'h341: v = m_epc;
      12'h342: v = m_cause;
      12'h343: v = m_tval;
      12'h344: v = (irq_sw ? 32'h8 : 0) + (irq_timer ? 32'h80 : 0) + (irq_ext ? 32'h800 : 0);
      12'hF14: v = HART_ID;
      12'hB00, 12'hC00: v = m_cycle[31:0];
      12'hB80, 12'hC80: v = m_cycle[63:32];
      12'hB02, 12'hC02: v = m_instret[31:0];
      12'hB82, 12'hC82: v = m_instret[63:32];
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic bit m_illegal();
    return wr_en && wr_op != 2'b00 && (wr_addr >= 12'hC00 || !m_known(wr_addr));
  endfunction

  always @(posedge clk) begin
    logic [31:0] old_v, new_v;
    logic [63:0] next_cycle, next_instret;
    bit          do_wr;
    if (!rst) begin
      m_valid = 1'b1;
      m_mie = 0; m_mpie = 0; m_ie = 0; m_tvec = MTVEC_RESET;
      m_scratch = 0; m_epc = 0; m_cause = 0; m_tval = 0; m_cycle = 0; m_instret = 0;
    end else if (m_valid) begin
      old_v = m_read(wr_addr);
      new_v = (wr_op == 2'b01) ? wr_data : (wr_op == 2'b10) ? (old_v | wr_data) : (old_v & ~wr_data);
      do_wr = wr_en && wr_op != 2'b00 && !m_illegal() && !trap_valid && !mret;
      next_cycle   = m_cycle + 1;
      next_instret = m_instret + (instr_retire ? 1 : 0);
      if (trap_valid) begin
        m_epc = {trap_epc[31:2], 2'b00}; m_cause = trap_cause; m_tval = trap_tval;
        m_mpie = m_mie; m_mie = 0;
      end else if (mret) begin
        m_mie = m_mpie; m_mpie = 1;
      end else if (do_wr) begin
        case (wr_addr)
          12'h300: begin m_mie = new_v[3]; m_mpie = new_v[7]; end
          12'h304: m_ie = {20'b0, new_v[11], 3'b0, new_v[7], 3'b0, new_v[3], 3'b0};
          12'h305: m_tvec = {new_v[31:2], 1'b0, new_v[0]};
          12'h340: m_scratch = new_v;
          12'h341: m_epc = {new_v[31:2], 2'b00};
          12'h342: m_cause = new_v;
          12'h343: m_tval = new_v;
          12'hB00: next_cycle = {m_cycle[63:32], new_v};
          12'hB80: next_cycle = {new_v, m_cycle[31:0]};
          12'hB02: next_instret = {m_instret[63:32], new_v};
          12'hB82: next_instret = {new_v, m_instret[31:0]};
          default: ;
        endcase
      end
      m_cycle   = next_cycle;
      m_instret = next_instret;
    end
  end

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid && rst) begin
      chk("model_rd1", rd1_data, m_read(rd1_addr));
      chk("model_rd2", rd2_data, m_read(rd2_addr));
      chk("model_wr_illegal", {31'b0, wr_illegal}, {31'b0, m_illegal()});
      chk("model_mtvec_out", mtvec_out, m_tvec);
      chk("model_mepc_out", mepc_out, m_epc);
      chk("model_irq_pending", {31'b0, irq_pending},
          {31'b0, m_mie && ((m_ie & m_read(12'h344)) != 0)});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; wr_op = 2'b00; wr_addr = 0; wr_data = 0; instr_retire = 0;
    trap_valid = 0; mret = 0; trap_cause = 0; trap_epc = 0; trap_tval = 0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_op = op; wr_data = d;
    tick();
    wr_en = 0; wr_op = 2'b00;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    rd1_addr = a;
    #1;
    chk(name, rd1_data, exp);
  endtask

  task automatic ill_chk(input string name, input logic [11:0] a, input logic [1:0] op,
                         input logic exp);
    wr_en = 1; wr_addr = a; wr_op = op; wr_data = 32'h5;
    #1;
    chk(name, {31'b0, wr_illegal}, {31'b0, exp});
    tick();
    wr_en = 0; wr_op = 2'b00;
  endtask

  initial begin
    idle();
    rst = 0; rd1_addr = 12'h300; rd2_addr = 12'hB80;
    irq_sw = 0; irq_timer = 0; irq_ext = 0;
    tick(); tick();
    rst = 1;

    // reset values and free-running mcycle
    rd_chk("rst_mstatus", 12'h300, 32'h00001800);
    rd_chk("rst_mtvec", 12'h305, MTVEC_RESET);
    rd_chk("rst_mcycle", 12'hB00, 32'd0);
    tick(); tick(); tick();
    rd_chk("mcycle_after_3", 12'hB00, 32'd3);

    // write / set / clear semantics and masks
    csr_wr(12'h305, 2'b01, 32'h80000003);
    rd_chk("mtvec_masked", 12'h305, 32'h80000001);
    csr_wr(12'h340, 2'b01, 32'h0000000F);
    csr_wr(12'h340, 2'b10, 32'h000000F0);
    rd_chk("mscratch_set", 12'h340, 32'h000000FF);
    csr_wr(12'h300, 2'b10, 32'hFFFFFFFF);
    rd_chk("mstatus_set_all", 12'h300, 32'h00001888);
    csr_wr(12'h300, 2'b11, 32'h00000008);
    rd_chk("mstatus_clr_mie", 12'h300, 32'h00001880);
    csr_wr(12'h300, 2'b11, 32'h00000080);
    csr_wr(12'h341, 2'b01, 32'h00000207);
    rd_chk("mepc_masked", 12'h341, 32'h00000204);
    csr_wr(12'h304, 2'b01, 32'hFFFFFFFF);
    rd_chk("mie_masked", 12'h304, 32'h00000888);
    csr_wr(12'h304, 2'b01, 32'h0);

    // illegal and ignored writes
    ill_chk("ill_c00", 12'hC00, 2'b01, 1'b1);
    ill_chk("ill_7ff", 12'h7FF, 2'b10, 1'b1);
    ill_chk("ill_f14", 12'hF14, 2'b01, 1'b1);
    ill_chk("noop_7ff", 12'h7FF, 2'b00, 1'b0);
    rd_chk("mhartid", 12'hF14, HART_ID);
    ill_chk("misa_ignored", 12'h301, 2'b01, 1'b0);
    rd_chk("misa_value", 12'h301, MISA_VALUE);
    irq_sw = 1; irq_ext = 1;
    rd_chk("mip_lines", 12'h344, 32'h00000808);
    irq_sw = 0; irq_ext = 0;

    // counter wrap and write-over-increment
    rd2_addr = 12'hB82;
    csr_wr(12'hB80, 2'b01, 32'h0);
    csr_wr(12'hB00, 2'b01, 32'hFFFFFFFF);
    rd_chk("mcycle_preload", 12'hB00, 32'hFFFFFFFF);
    rd_chk("mcycleh_preload", 12'hB80, 32'h0);
    tick();
    rd_chk("mcycle_wrap_lo", 12'hB00, 32'h0);
    rd_chk("mcycle_wrap_hi", 12'hC80, 32'h1);
    instr_retire = 1;
    csr_wr(12'hB02, 2'b01, 32'h00001234);
    rd_chk("minstret_written", 12'hB02, 32'h00001234);
    rd_chk("instret_shadow", 12'hC02, 32'h00001234);
    tick();
    instr_retire = 0;
    rd_chk("minstret_inc", 12'hB02, 32'h00001235);

    // interrupt pending, trap entry, mret
    rd2_addr = 12'h342;
    csr_wr(12'h300, 2'b10, 32'h00000008);
    csr_wr(12'h304, 2'b01, 32'h00000080);
    irq_timer = 1;
    #1;
    chk("irq_pending_on", {31'b0, irq_pending}, 32'd1);
    trap_valid = 1; trap_cause = 32'h80000007; trap_epc = 32'h00000103; trap_tval = 32'h55;
    tick();
    trap_valid = 0;
    #1;
    chk("trap_mepc", mepc_out, 32'h00000100);
    rd_chk("trap_mstatus", 12'h300, 32'h00001880);
    chk("trap_irq_off", {31'b0, irq_pending}, 32'd0);
    rd_chk("trap_mcause", 12'h342, 32'h80000007);
    mret = 1;
    tick();
    mret = 0;
    rd_chk("mret_mstatus", 12'h300, 32'h00001888);

    // trap + mret + write in one cycle, then reset mid-sequence
    trap_valid = 1; trap_epc = 32'h00000202; trap_cause = 32'h2; mret = 1;
    wr_en = 1; wr_addr = 12'h340; wr_op = 2'b01; wr_data = 32'hDEAD;
    #1;
    chk("combo_not_illegal", {31'b0, wr_illegal}, 32'd0);
    tick();
    idle();
    rd_chk("combo_mscratch", 12'h340, 32'h000000FF);
    rd_chk("combo_mstatus", 12'h300, 32'h00001880);
    chk("combo_mepc", mepc_out, 32'h00000200);
    rst = 0;
    wr_en = 1; wr_addr = 12'h340; wr_op = 2'b01; wr_data = 32'h1234;
    tick();
    rst = 1;
    idle();
    rd_chk("rst2_mscratch", 12'h340, 32'h0);
    rd_chk("rst2_mstatus", 12'h300, 32'h00001800);
    chk("rst2_mtvec", mtvec_out, MTVEC_RESET);
    rd_chk("rst2_mcycle", 12'hB00, 32'h0);
    irq_timer = 0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
